// File: rtl/e6_timer_ctrl.sv
// Timer control core: register-strobe client, prescaler plus down-counter FSM, and interrupt pend/ack/enable logic.
// Latency: read data and valid arrive 1 cycle after reg_rd_en; irq and running are registered, 1 cycle after their source state.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
module e6_timer_ctrl #(
    parameter int CNT_W           = 32,
    parameter int ADDR_W          = 5,
    parameter bit IRQ_ACTIVE_HIGH = 1'b1
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] reg_wr_addr,
    input  logic [31:0]       reg_wr_data,
    input  logic              reg_rd_en,
    input  logic [ADDR_W-1:0] reg_rd_addr,
    output logic [31:0]       reg_rd_data,
    output logic              reg_rd_valid,
    output logic              running,
    output logic              irq
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // Word indices of the register map (byte address bits [1:0] are ignored).
    localparam logic [ADDR_W-3:0] A_CTRL  = (ADDR_W-2)'(0);
    localparam logic [ADDR_W-3:0] A_LOAD  = (ADDR_W-2)'(1);
    localparam logic [ADDR_W-3:0] A_PRESC = (ADDR_W-2)'(2);
    localparam logic [ADDR_W-3:0] A_COUNT = (ADDR_W-2)'(3);
    localparam logic [ADDR_W-3:0] A_GIE   = (ADDR_W-2)'(4);
    localparam logic [ADDR_W-3:0] A_IER   = (ADDR_W-2)'(5);
    localparam logic [ADDR_W-3:0] A_ISR   = (ADDR_W-2)'(6);

    localparam logic IRQ_IDLE_LVL = IRQ_ACTIVE_HIGH ? 1'b0 : 1'b1;

    state_t             state_q, state_d;
    logic               periodic_q, periodic_d;
    logic [CNT_W-1:0]   load_q, load_d;
    logic [CNT_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d;
    logic               gie_q, gie_d;
    logic [1:0]         ier_q, ier_d;
    logic [1:0]         isr_q, isr_d;
    logic               irq_q, irq_d;
    logic               running_q, running_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    logic [ADDR_W-3:0]  wr_idx, rd_idx;
    logic               start_wr, stop_wr, expire, irq_active;
    logic [1:0]         isr_clr;
    logic               unused_addr_bits;

    assign wr_idx = reg_wr_addr[ADDR_W-1:2];
    assign rd_idx = reg_rd_addr[ADDR_W-1:2];
    assign unused_addr_bits = ^{reg_wr_addr[1:0], reg_rd_addr[1:0]};

    // Register writes, counter FSM, interrupt pend/ack and read mux.
    always_comb begin
        state_d    = state_q;
        periodic_d = periodic_q;
        load_d     = load_q;
        presc_d    = presc_q;
        count_d    = count_q;
        pcnt_d     = pcnt_q;
        gie_d      = gie_q;
        ier_d      = ier_q;
        expire     = 1'b0;
        rd_data_d  = 32'd0;
        rd_valid_d = reg_rd_en;

        start_wr = reg_wr_en && (wr_idx == A_CTRL) && reg_wr_data[0];
        stop_wr  = reg_wr_en && (wr_idx == A_CTRL) && reg_wr_data[1];
        isr_clr  = (reg_wr_en && (wr_idx == A_ISR)) ? reg_wr_data[1:0] : 2'b00;

        if (reg_wr_en) begin
            case (wr_idx)
                A_CTRL:  periodic_d = reg_wr_data[2];
                A_LOAD:  load_d     = reg_wr_data[CNT_W-1:0];
                A_PRESC: presc_d    = reg_wr_data[CNT_W-1:0];
                A_GIE:   gie_d      = reg_wr_data[0];
                A_IER:   ier_d      = reg_wr_data[1:0];
                default: ;
            endcase
        end

        // The FSM works from the registered LOAD/PRESC/PERIODIC, so writes
        // during RUN only matter at the next tick comparison or reload.
        case (state_q)
            S_IDLE: begin
                if (start_wr && !stop_wr) begin
                    state_d = S_RUN;
                    count_d = load_q;
                    pcnt_d  = '0;
                end
            end
            S_RUN: begin
                if (stop_wr) begin
                    state_d = S_IDLE;
                    pcnt_d  = '0;
                end else if (start_wr) begin
                    count_d = load_q;
                    pcnt_d  = '0;
                end else if (pcnt_q == presc_q) begin
                    pcnt_d = '0;
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        expire = 1'b1;
                        if (periodic_q) count_d = load_q;
                        else            state_d = S_IDLE;
                    end
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Set beats a coincident write-1-to-clear; OVR looks at EXP before any ack.
        isr_d = (isr_q & ~isr_clr) | {expire & isr_q[0], expire};

        irq_active = gie_q & (|(isr_q & ier_q));
        irq_d      = IRQ_ACTIVE_HIGH ? irq_active : ~irq_active;
        running_d  = (state_d == S_RUN);

        if (reg_rd_en) begin
            case (rd_idx)
                A_CTRL:  rd_data_d = {29'd0, periodic_q, 2'b00};
                A_LOAD:  rd_data_d = 32'(load_q);
                A_PRESC: rd_data_d = 32'(presc_q);
                A_COUNT: rd_data_d = 32'(count_q);
                A_GIE:   rd_data_d = {31'd0, gie_q};
                A_IER:   rd_data_d = {30'd0, ier_q};
                A_ISR:   rd_data_d = {30'd0, isr_q};
                default: rd_data_d = 32'd0;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= S_IDLE;
            periodic_q <= 1'b0;
            load_q     <= '0;
            presc_q    <= '0;
            count_q    <= '0;
            pcnt_q     <= '0;
            gie_q      <= 1'b0;
            ier_q      <= 2'b00;
            isr_q      <= 2'b00;
            irq_q      <= IRQ_IDLE_LVL;
            running_q  <= 1'b0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            periodic_q <= periodic_d;
            load_q     <= load_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            pcnt_q     <= pcnt_d;
            gie_q      <= gie_d;
            ier_q      <= ier_d;
            isr_q      <= isr_d;
            irq_q      <= irq_d;
            running_q  <= running_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign reg_rd_data  = rd_data_q;
    assign reg_rd_valid = rd_valid_q;
    assign running      = running_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_e6_timer_ctrl.sv
// Bench for e6_timer_ctrl: directed scenarios plus randomized timer runs.
// Expected values come from closed-form period arithmetic, not a cycle model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_e6_timer_ctrl;

    localparam logic [4:0] A_CTRL = 5'h00, A_LOAD = 5'h04, A_PRESC = 5'h08, A_COUNT = 5'h0C;
    localparam logic [4:0] A_GIE = 5'h10, A_IER = 5'h14, A_ISR = 5'h18, A_UNM = 5'h1C;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        reg_wr_en = 1'b0;
    logic [4:0]  reg_wr_addr = '0;
    logic [31:0] reg_wr_data = '0;
    logic        reg_rd_en = 1'b0;
    logic [4:0]  reg_rd_addr = '0;
    logic [31:0] reg_rd_data;
    logic        reg_rd_valid;
    logic        running;
    logic        irq;

    int vec = 0;
    int err = 0;

    e6_timer_ctrl #(.CNT_W(32), .ADDR_W(5), .IRQ_ACTIVE_HIGH(1'b1)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
        .running(running), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
        cyc();
        reg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic v);
        reg_rd_en = 1'b1; reg_rd_addr = a;
        cyc();
        reg_rd_en = 1'b0;
        d = reg_rd_data; v = reg_rd_valid;
    endtask

    // Reference model. j counts clock edges after the START edge; a tick
    // falls on every (P+1)th edge, an expiry on every (L+1)th tick.
    function automatic int m_count(int L, int P, bit per, int j);
        int ticks = j / (P + 1);
        if (per) return L - (ticks % (L + 1));
        return (ticks <= L) ? L - ticks : 0;
    endfunction

    function automatic int m_nexp(int L, int P, bit per, int j);
        int t = (L + 1) * (P + 1);
        if (per) return j / t;
        return (j >= t) ? 1 : 0;
    endfunction

    function automatic logic [1:0] m_isr(int L, int P, bit per, int j);
        int n = m_nexp(L, P, per, j);
        return {n >= 2, n >= 1};
    endfunction

    task automatic test_reset();
        logic [31:0] d; logic v;
        ARESET = 1'b1; cyc(); cyc(); ARESET = 1'b0;
        vec++; if (running !== 1'b0) begin err++; $display("FAIL reset_running: got %0b want 0", running); end
        vec++; if (irq !== 1'b0) begin err++; $display("FAIL reset_irq: got %0b want 0", irq); end
        vec++; if (reg_rd_valid !== 1'b0 || reg_rd_data !== 32'd0) begin err++; $display("FAIL reset_rdport: got valid=%0b data=%h want 0/0", reg_rd_valid, reg_rd_data); end
        for (int a = 0; a < 32; a += 4) begin
            rd(5'(a), d, v);
            vec++; if (d !== 32'd0 || v !== 1'b1) begin err++; $display("FAIL reset_read_%h: got data=%h valid=%0b want 0/1", a, d, v); end
        end
        // Reset in the middle of a count.
        wr(A_LOAD, 32'd7); wr(A_PRESC, 32'd100); wr(A_CTRL, 32'h1);
        rd(A_COUNT, d, v);
        vec++; if (d !== 32'd7) begin err++; $display("FAIL midrun_count_before: got %0d want 7", d); end
        ARESET = 1'b1; cyc(); ARESET = 1'b0;
        vec++; if (running !== 1'b0) begin err++; $display("FAIL midrun_reset_running: got %0b want 0", running); end
        rd(A_COUNT, d, v);
        vec++; if (d !== 32'd0) begin err++; $display("FAIL midrun_reset_count: got %0d want 0", d); end
        rd(A_ISR, d, v);
        vec++; if (d !== 32'd0) begin err++; $display("FAIL midrun_reset_isr: got %h want 0", d); end
        rd(A_LOAD, d, v);
        vec++; if (d !== 32'd0) begin err++; $display("FAIL midrun_reset_load: got %0d want 0", d); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d; logic v;
        wr(A_LOAD, 32'd3); wr(A_PRESC, 32'd1); wr(A_GIE, 32'd1); wr(A_IER, 32'd1);
        wr(A_CTRL, 32'h1);
        vec++; if (running !== 1'b1) begin err++; $display("FAIL oneshot_start_running: got %0b want 1", running); end
        for (int k = 1; k <= 10; k++) begin
            cyc();
            vec++; if (running !== (k < 8)) begin err++; $display("FAIL oneshot_running_k%0d: got %0b want %0b", k, running, k < 8); end
            vec++; if (irq !== (k >= 9)) begin err++; $display("FAIL oneshot_irq_k%0d: got %0b want %0b", k, irq, k >= 9); end
        end
        rd(A_ISR, d, v);
        vec++; if (d !== 32'h1) begin err++; $display("FAIL oneshot_isr: got %h want 1", d); end
        rd(A_COUNT, d, v);
        vec++; if (d !== 32'd0) begin err++; $display("FAIL oneshot_count: got %0d want 0", d); end
        wr(A_ISR, 32'h3); cyc();
    endtask

    task automatic test_periodic_ovr();
        logic [31:0] d; logic v;
        wr(A_LOAD, 32'd2); wr(A_PRESC, 32'd0); wr(A_IER, 32'd3);
        wr(A_CTRL, 32'h5);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            vec++; if (irq !== (k >= 4)) begin err++; $display("FAIL periodic_irq_k%0d: got %0b want %0b", k, irq, k >= 4); end
        end
        rd(A_ISR, d, v);
        vec++; if (d !== 32'h3) begin err++; $display("FAIL periodic_ovr_isr: got %h want 3", d); end
        wr(A_CTRL, 32'h2);
        vec++; if (running !== 1'b0) begin err++; $display("FAIL periodic_stop_running: got %0b want 0", running); end
        wr(A_ISR, 32'h3);
        vec++; if (irq !== 1'b1) begin err++; $display("FAIL periodic_ack_irq_same: got %0b want 1", irq); end
        cyc();
        vec++; if (irq !== 1'b0) begin err++; $display("FAIL periodic_ack_irq_next: got %0b want 0", irq); end
        rd(A_ISR, d, v);
        vec++; if (d !== 32'h0) begin err++; $display("FAIL periodic_ack_isr: got %h want 0", d); end
    endtask

    task automatic test_ack_collision();
        logic [31:0] d; logic v;
        wr(A_IER, 32'd1);
        wr(A_CTRL, 32'h5);           // START edge
        cyc(); cyc();
        wr(A_ISR, 32'h1);            // lands on the first expiry edge
        cyc();
        vec++; if (irq !== 1'b1) begin err++; $display("FAIL collide_irq: got %0b want 1", irq); end
        rd(A_ISR, d, v);
        vec++; if (d !== 32'h1) begin err++; $display("FAIL collide_isr: got %h want 1", d); end
        cyc();
        vec++; if (irq !== 1'b1) begin err++; $display("FAIL collide_irq_hold: got %0b want 1", irq); end
        wr(A_CTRL, 32'h2); wr(A_ISR, 32'h3); cyc();
    endtask

    task automatic test_stop();
        logic [31:0] d; logic v;
        wr(A_LOAD, 32'd10); wr(A_PRESC, 32'd0);
        wr(A_CTRL, 32'h1);
        cyc(); cyc(); cyc(); cyc();
        wr(A_CTRL, 32'h2);
        rd(A_COUNT, d, v);
        vec++; if (d !== 32'd6) begin err++; $display("FAIL stop_count: got %0d want 6", d); end
        cyc(); cyc(); cyc();
        rd(A_COUNT, d, v);
        vec++; if (d !== 32'd6 || running !== 1'b0) begin err++; $display("FAIL stop_hold: got count=%0d running=%0b want 6/0", d, running); end
        wr(A_CTRL, 32'h3);
        vec++; if (running !== 1'b0) begin err++; $display("FAIL startstop_running: got %0b want 0", running); end
        cyc();
        rd(A_COUNT, d, v);
        vec++; if (d !== 32'd6 || running !== 1'b0) begin err++; $display("FAIL startstop_count: got count=%0d running=%0b want 6/0", d, running); end
    endtask

    task automatic test_gie();
        logic [31:0] d; logic v;
        wr(A_GIE, 32'd0); wr(A_IER, 32'd1); wr(A_ISR, 32'h3); wr(A_LOAD, 32'd0);
        wr(A_CTRL, 32'h1);
        cyc(); cyc(); cyc();
        vec++; if (irq !== 1'b0 || running !== 1'b0) begin err++; $display("FAIL gie_off: got irq=%0b running=%0b want 0/0", irq, running); end
        rd(A_ISR, d, v);
        vec++; if (d !== 32'h1) begin err++; $display("FAIL gie_off_isr: got %h want 1", d); end
        wr(A_GIE, 32'd1);
        vec++; if (irq !== 1'b0) begin err++; $display("FAIL gie_on_same: got %0b want 0", irq); end
        cyc();
        vec++; if (irq !== 1'b1) begin err++; $display("FAIL gie_on_next: got %0b want 1", irq); end
        wr(A_UNM, 32'hFFFF_FFFF);
        reg_rd_en = 1'b1; reg_rd_addr = A_UNM;
        cyc();
        reg_rd_en = 1'b0;
        vec++; if (reg_rd_valid !== 1'b1 || reg_rd_data !== 32'd0) begin err++; $display("FAIL unmapped_read: got valid=%0b data=%h want 1/0", reg_rd_valid, reg_rd_data); end
        cyc();
        vec++; if (reg_rd_valid !== 1'b0) begin err++; $display("FAIL rd_valid_pulse: got %0b want 0", reg_rd_valid); end
        // Simultaneous write and read of LOAD returns the old value.
        wr(A_LOAD, 32'd5);
        reg_wr_en = 1'b1; reg_wr_addr = A_LOAD; reg_wr_data = 32'd9;
        reg_rd_en = 1'b1; reg_rd_addr = A_LOAD;
        cyc();
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        vec++; if (reg_rd_data !== 32'd5) begin err++; $display("FAIL rw_same_old: got %0d want 5", reg_rd_data); end
        rd(A_LOAD, d, v);
        vec++; if (d !== 32'd9) begin err++; $display("FAIL rw_same_new: got %0d want 9", d); end
        wr(A_CTRL, 32'h4);
        rd(A_CTRL, d, v);
        vec++; if (d !== 32'h4) begin err++; $display("FAIL ctrl_readback: got %h want 4", d); end
    endtask

    task automatic test_random_runs();
        logic [31:0] d; logic v;
        for (int it = 0; it < 30; it++) begin
            int L, P, K, rdk, t;
            bit per, g;
            logic [1:0] ie, s;
            L = int'($urandom_range(0, 6)); P = int'($urandom_range(0, 3));
            per = 1'($urandom_range(0, 1)); g = 1'($urandom_range(0, 1));
            ie = 2'($urandom_range(0, 3));
            t = (L + 1) * (P + 1);
            K = per ? 2 * t + 2 : t + 3;
            rdk = int'($urandom_range(1, K));
            wr(A_CTRL, 32'h2); wr(A_LOAD, 32'(L)); wr(A_PRESC, 32'(P));
            wr(A_GIE, 32'(g)); wr(A_IER, 32'(ie)); wr(A_ISR, 32'h3); cyc();
            wr(A_CTRL, 32'h1 | (32'(per) << 2));
            vec++; if (running !== 1'b1) begin err++; $display("FAIL rnd%0d_start: got %0b want 1", it, running); end
            for (int k = 1; k <= K; k++) begin
                if (k == rdk) begin reg_rd_en = 1'b1; reg_rd_addr = A_COUNT; end
                cyc();
                reg_rd_en = 1'b0;
                s = m_isr(L, P, per, k - 1);
                vec++; if (running !== (per || k < t)) begin err++; $display("FAIL rnd%0d_running_k%0d: got %0b want %0b (L=%0d P=%0d per=%0b)", it, k, running, per || k < t, L, P, per); end
                vec++; if (irq !== (g & (|(s & ie)))) begin err++; $display("FAIL rnd%0d_irq_k%0d: got %0b want %0b (L=%0d P=%0d per=%0b)", it, k, irq, g & (|(s & ie)), L, P, per); end
                if (k == rdk) begin
                    vec++; if (reg_rd_valid !== 1'b1 || reg_rd_data !== 32'(m_count(L, P, per, k - 1))) begin err++; $display("FAIL rnd%0d_count_k%0d: got %0d valid=%0b want %0d (L=%0d P=%0d per=%0b)", it, k, reg_rd_data, reg_rd_valid, m_count(L, P, per, k - 1), L, P, per); end
                end
            end
            rd(A_ISR, d, v);
            vec++; if (d !== {30'd0, m_isr(L, P, per, K)}) begin err++; $display("FAIL rnd%0d_isr: got %h want %h (L=%0d P=%0d per=%0b)", it, d, m_isr(L, P, per, K), L, P, per); end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic_ovr();
        test_ack_collision();
        test_stop();
        test_gie();
        test_random_runs();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
